// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: entry record, issue record, status encoding and widths.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package rob_pkg;

    localparam int ROB_ENTRIES   = 128;
    localparam int ROB_IW        = $clog2(ROB_ENTRIES);
    localparam int ADDR_BITS     = 32;
    localparam int ARCH_REG_BITS = 5;
    localparam int UOP_BITS      = 16;

    // Dependency pointer: MSB set means "no dependency", low ROB_IW bits index the ROB.
    typedef logic [ROB_IW:0] rob_dep_t;

    typedef enum logic [1:0] {
        ST_READY     = 2'd0,
        ST_ISSUED    = 2'd1,
        ST_DONE      = 2'd2,
        ST_EXCEPTION = 2'd3
    } rob_status_e;

    typedef struct packed {
        logic [ADDR_BITS-1:0]     pc;
        logic [ADDR_BITS-1:0]     next_pc;
        logic [UOP_BITS-1:0]      uop;
        logic [ARCH_REG_BITS-1:0] dest_reg;
        rob_dep_t [1:0]           dependent_entries;
        rob_status_e              status;
    } rob_entry;

    typedef struct packed {
        logic                valid;
        logic [UOP_BITS-1:0] uop;
        logic [ROB_IW-1:0]   ptr;
    } rob_issue;

endpackage

// File: rtl/rob_buffer_if.sv
// Reorder-buffer port bundle: rename allocation, in-order issue, writeback, commit and flush.
// Latency: none (wiring only); ROB_PERF_CNT_EN adds the perf counter signals.
// Backpressure: alloc_valid/alloc_ready and issue_o.valid/issue_ready handshakes.
interface rob_buffer_if;
    import rob_pkg::*;

    logic                     alloc_valid;
    logic                     alloc_ready;
    rob_entry                 alloc_entry;
    logic [ROB_IW-1:0]        alloc_ptr;
    rob_issue                 issue_o;
    logic                     issue_ready;
    logic                     wb_valid;
    logic [ROB_IW-1:0]        wb_ptr;
    logic                     wb_exception;
    logic                     commit_valid;
    logic [ARCH_REG_BITS-1:0] commit_dest_reg;
    logic [ADDR_BITS-1:0]     commit_pc;
    logic                     flush;
    logic [ADDR_BITS-1:0]     redirect_pc;
    logic [ROB_IW:0]          count;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]              perf_commits;
    logic [31:0]              perf_full_stalls;
`endif

    modport slave (
        input  alloc_valid, alloc_entry, issue_ready, wb_valid, wb_ptr, wb_exception,
        output alloc_ready, alloc_ptr, issue_o, commit_valid, commit_dest_reg, commit_pc,
               flush, redirect_pc, count
`ifdef ROB_PERF_CNT_EN
        , output perf_commits, perf_full_stalls
`endif
    );

    modport master (
        output alloc_valid, alloc_entry, issue_ready, wb_valid, wb_ptr, wb_exception,
        input  alloc_ready, alloc_ptr, issue_o, commit_valid, commit_dest_reg, commit_pc,
               flush, redirect_pc, count
`ifdef ROB_PERF_CNT_EN
        , input perf_commits, perf_full_stalls
`endif
    );

endinterface

// File: rtl/rob_buffer.sv
// Reorder buffer: circular queue, in-order alloc/issue/commit, out-of-order writeback, flush on faulting head.
// Latency: alloc/wb visible the cycle after the edge; issue_o and commit_valid are combinational from state.
// Backpressure: alloc_ready low when full or flushing; issue_o held until issue_ready. Option: ROB_PERF_CNT_EN.
module rob_buffer
    import rob_pkg::*;
#(
    // Must match rob_pkg::ROB_ENTRIES: dependency and pointer fields of the shared types use that width.
    parameter int ROB_ENTRIES = rob_pkg::ROB_ENTRIES
) (
    input  logic        clk,
    input  logic        rst_n,
    rob_buffer_if.slave bus
);

    localparam int          IW       = $clog2(ROB_ENTRIES);
    localparam logic [IW:0] FULL_CNT = (IW+1)'(ROB_ENTRIES);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          head_q, tail_q, iss_q;
    logic [IW:0]            count_q, count_d;
    logic [ROB_ENTRIES-1:0] valid_q;
    logic                   alloc_ready_q, alloc_ready_d;

    // Per-field storage; valid_q qualifies every read so none of it needs a reset.
    logic [ADDR_BITS-1:0]     pc_mem   [ROB_ENTRIES];
    logic [UOP_BITS-1:0]      uop_mem  [ROB_ENTRIES];
    logic [ARCH_REG_BITS-1:0] dst_mem  [ROB_ENTRIES];
    rob_dep_t                 dep0_mem [ROB_ENTRIES];
    rob_dep_t                 dep1_mem [ROB_ENTRIES];
    rob_status_e              st_mem   [ROB_ENTRIES];

    rob_dep_t iss_dep0, iss_dep1;
    logic     dep0_ok, dep1_ok;
    logic     issue_vld, issue_fire, commit_vld, head_exc, alloc_fire, wb_hit;

    // next_pc is carried by rename for other consumers and the incoming status is overwritten.
    logic unused_alloc_fields;
    assign unused_alloc_fields = ^{bus.alloc_entry.next_pc, bus.alloc_entry.status};

    // Readiness of the in-order issue candidate, head commit/fault detection and handshakes.
    always_comb begin
        iss_dep0   = dep0_mem[iss_q];
        iss_dep1   = dep1_mem[iss_q];
        dep0_ok    = iss_dep0[IW] || !valid_q[iss_dep0[IW-1:0]] || (st_mem[iss_dep0[IW-1:0]] == ST_DONE);
        dep1_ok    = iss_dep1[IW] || !valid_q[iss_dep1[IW-1:0]] || (st_mem[iss_dep1[IW-1:0]] == ST_DONE);
        issue_vld  = valid_q[iss_q] && (st_mem[iss_q] == ST_READY) && dep0_ok && dep1_ok
                     && (state_q == S_RUN);
        issue_fire = issue_vld && bus.issue_ready;
        commit_vld = valid_q[head_q] && (st_mem[head_q] == ST_DONE) && (state_q == S_RUN);
        head_exc   = valid_q[head_q] && (st_mem[head_q] == ST_EXCEPTION);
        alloc_fire = bus.alloc_valid && alloc_ready_q;
        wb_hit     = bus.wb_valid && (state_q == S_RUN) && valid_q[bus.wb_ptr]
                     && (st_mem[bus.wb_ptr] == ST_ISSUED);
    end

    // Next state: a faulting head triggers a single flush cycle; occupancy and registered alloc_ready follow.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_RUN: begin
                if (head_exc) begin
                    state_d = S_FLUSH;
                end
                count_d = count_q + {{IW{1'b0}}, alloc_fire} - {{IW{1'b0}}, commit_vld};
            end
            S_FLUSH: begin
                state_d = S_RUN;
                count_d = '0;
            end
            default: begin
                state_d = S_RUN;
                count_d = '0;
            end
        endcase
        alloc_ready_d = (count_d < FULL_CNT) && (state_d == S_RUN);
    end

    // Control state: pointers, valid bits, occupancy and FSM; flush clears the whole queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            count_q       <= '0;
            alloc_ready_q <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            iss_q         <= '0;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            alloc_ready_q <= alloc_ready_d;
            if (state_q == S_FLUSH) begin
                head_q  <= '0;
                tail_q  <= '0;
                iss_q   <= '0;
                valid_q <= '0;
            end else begin
                if (alloc_fire) begin
                    valid_q[tail_q] <= 1'b1;
                    tail_q          <= tail_q + 1'b1;
                end
                if (commit_vld) begin
                    valid_q[head_q] <= 1'b0;
                    head_q          <= head_q + 1'b1;
                end
                if (issue_fire) begin
                    iss_q <= iss_q + 1'b1;
                end
            end
        end
    end

    // Entry payload and status: written on alloc, issue handshake and accepted writeback.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pc_mem[tail_q]   <= bus.alloc_entry.pc;
            uop_mem[tail_q]  <= bus.alloc_entry.uop;
            dst_mem[tail_q]  <= bus.alloc_entry.dest_reg;
            dep0_mem[tail_q] <= bus.alloc_entry.dependent_entries[0];
            dep1_mem[tail_q] <= bus.alloc_entry.dependent_entries[1];
            st_mem[tail_q]   <= ST_READY;
        end
        if (issue_fire) begin
            st_mem[iss_q] <= ST_ISSUED;
        end
        if (wb_hit) begin
            st_mem[bus.wb_ptr] <= bus.wb_exception ? ST_EXCEPTION : ST_DONE;
        end
    end

    // Outputs; payloads are zeroed when their qualifier is low so reset leaves every output at 0.
    always_comb begin
        bus.alloc_ready     = alloc_ready_q;
        bus.alloc_ptr       = tail_q;
        bus.issue_o.valid   = issue_vld;
        bus.issue_o.uop     = valid_q[iss_q] ? uop_mem[iss_q] : '0;
        bus.issue_o.ptr     = iss_q;
        bus.commit_valid    = commit_vld;
        bus.commit_dest_reg = commit_vld ? dst_mem[head_q] : '0;
        bus.commit_pc       = commit_vld ? pc_mem[head_q] : '0;
        bus.flush           = (state_q == S_FLUSH);
        bus.redirect_pc     = (state_q == S_FLUSH) ? pc_mem[head_q] : '0;
        bus.count           = count_q;
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commits_q, perf_full_stalls_q;

    // Free-running perf counters: retirements and cycles where rename was refused; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_commits_q     <= '0;
            perf_full_stalls_q <= '0;
        end else begin
            if (commit_vld) begin
                perf_commits_q <= perf_commits_q + 32'd1;
            end
            if (bus.alloc_valid && !alloc_ready_q) begin
                perf_full_stalls_q <= perf_full_stalls_q + 32'd1;
            end
        end
    end

    assign bus.perf_commits     = perf_commits_q;
    assign bus.perf_full_stalls = perf_full_stalls_q;
`endif

endmodule

// File: tb/tb_rob_buffer.sv
// Bench for rob_buffer: directed vector table, hand-written corner sequences, randomized run vs queue model.
// Latency: outputs sampled at negedge, inputs driven right after sampling.
// Backpressure: issue_ready and alloc_valid randomized in the random phase.
module tb_rob_buffer;
    import rob_pkg::*;

    localparam int N  = ROB_ENTRIES;
    localparam int IW = ROB_IW;
    localparam rob_dep_t NODEP = {1'b1, {IW{1'b0}}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_buffer_if bus();

    rob_buffer #(.ROB_ENTRIES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int alloc_seq = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.alloc_valid  = 1'b0;
        bus.alloc_entry  = '0;
        bus.issue_ready  = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_ptr       = '0;
        bus.wb_exception = 1'b0;
    endtask

    // Directed allocation: pc = 0x1000 + 4*sequence number since the last reset.
    task automatic drive_alloc(input bit av, input rob_dep_t d0);
        bus.alloc_valid = av;
        bus.alloc_entry = '0;
        if (av) begin
            bus.alloc_entry.pc                   = 32'h1000 + 32'(alloc_seq * 4);
            bus.alloc_entry.next_pc              = 32'h1004 + 32'(alloc_seq * 4);
            bus.alloc_entry.uop                  = 16'(16'h0a00 + alloc_seq);
            bus.alloc_entry.dest_reg             = 5'(alloc_seq);
            bus.alloc_entry.dependent_entries[0] = d0;
            bus.alloc_entry.dependent_entries[1] = NODEP;
            alloc_seq++;
        end
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        alloc_seq = 0;
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int av; int dep; int ir; int wv; int wp;
        int e_ar; int e_aptr; int e_iv; int e_iptr; int e_cv; int e_cpc; int e_cnt;
    } vec_t;

    function automatic vec_t mkv(int av, int dep, int ir, int wv, int wp,
                                 int ar, int aptr, int iv, int iptr, int cv, int cpc, int cnt);
        vec_t v;
        v.av = av; v.dep = dep; v.ir = ir; v.wv = wv; v.wp = wp;
        v.e_ar = ar; v.e_aptr = aptr; v.e_iv = iv; v.e_iptr = iptr;
        v.e_cv = cv; v.e_cpc = cpc; v.e_cnt = cnt;
        return v;
    endfunction

    vec_t tbl[20];

    // ---------------- reference model ----------------
    localparam int M_RDY = 0, M_ISS = 1, M_DONE = 2, M_EXC = 3;
    typedef struct {
        int          ptr;
        logic [31:0] pc;
        logic [15:0] uop;
        logic [4:0]  dst;
        rob_dep_t    d0;
        rob_dep_t    d1;
        int          st;
    } mrec_t;

    mrec_t mq[$];
    int    m_issued;
    int    m_next;
    bit    m_flush;
    int    m_commits;
    int    m_stalls;

    function automatic int mfind(int p);
        foreach (mq[k]) if (mq[k].ptr == p) return k;
        return -1;
    endfunction

    function automatic bit dep_sat(rob_dep_t d);
        int k;
        if (d[IW]) return 1'b1;
        k = mfind(int'(d[IW-1:0]));
        return (k < 0) || (mq[k].st == M_DONE);
    endfunction

    initial begin
        int e_ar, e_iv, e_iptr, e_cv, e_cnt;
        logic [31:0] e_cpc, e_rpc;
        logic [4:0]  e_cdst;
        logic [15:0] e_uop;
        bit av, ir, wv, wx, go, afire, ifire;
        int wp, k;
        mrec_t nr;
        int iss_list[$];

        set_idle();
        rst_n = 1'b0;
        #2;
        chk("reset_alloc_ready", bus.alloc_ready, 0);
        chk("reset_count", bus.count, 0);
        chk("reset_issue_valid", bus.issue_o.valid, 0);
        chk("reset_commit_valid", bus.commit_valid, 0);
        chk("reset_flush", bus.flush, 0);
        do_reset();

        // Rows: inputs | outputs expected at the start of that cycle.
        tbl[0]  = mkv(1, NODEP, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(1, NODEP, 1, 0, 0,  1, 1, 1, 0, 0, 0, 1);
        tbl[2]  = mkv(1, NODEP, 1, 0, 0,  1, 2, 1, 1, 0, 0, 2);
        tbl[3]  = mkv(0, NODEP, 1, 0, 0,  1, 3, 1, 2, 0, 0, 3);
        tbl[4]  = mkv(0, NODEP, 0, 1, 2,  1, 3, 0, 3, 0, 0, 3);
        tbl[5]  = mkv(0, NODEP, 0, 1, 0,  1, 3, 0, 3, 0, 0, 3);
        tbl[6]  = mkv(0, NODEP, 0, 1, 1,  1, 3, 0, 3, 1, 32'h1000, 3);
        tbl[7]  = mkv(0, NODEP, 0, 0, 0,  1, 3, 0, 3, 1, 32'h1004, 2);
        tbl[8]  = mkv(0, NODEP, 0, 0, 0,  1, 3, 0, 3, 1, 32'h1008, 1);
        tbl[9]  = mkv(0, NODEP, 0, 0, 0,  1, 3, 0, 3, 0, 0, 0);
        tbl[10] = mkv(1, NODEP, 0, 0, 0,  1, 3, 0, 3, 0, 0, 0);
        tbl[11] = mkv(1, 3,     1, 0, 0,  1, 4, 1, 3, 0, 0, 1);
        tbl[12] = mkv(0, NODEP, 0, 0, 0,  1, 5, 0, 4, 0, 0, 2);
        tbl[13] = mkv(0, NODEP, 0, 1, 3,  1, 5, 0, 4, 0, 0, 2);
        tbl[14] = mkv(0, NODEP, 1, 0, 0,  1, 5, 1, 4, 1, 32'h100c, 2);
        tbl[15] = mkv(0, NODEP, 0, 1, 5,  1, 5, 0, 5, 0, 0, 1);
        tbl[16] = mkv(0, NODEP, 0, 1, 4,  1, 5, 0, 5, 0, 0, 1);
        tbl[17] = mkv(0, NODEP, 0, 1, 4,  1, 5, 0, 5, 1, 32'h1010, 1);
        tbl[18] = mkv(0, NODEP, 0, 1, 4,  1, 5, 0, 5, 0, 0, 0);
        tbl[19] = mkv(0, NODEP, 0, 0, 0,  1, 5, 0, 5, 0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            chk($sformatf("tbl%0d_alloc_ready", r), bus.alloc_ready, tbl[r].e_ar);
            chk($sformatf("tbl%0d_alloc_ptr", r), bus.alloc_ptr, tbl[r].e_aptr);
            chk($sformatf("tbl%0d_issue_valid", r), bus.issue_o.valid, tbl[r].e_iv);
            chk($sformatf("tbl%0d_issue_ptr", r), bus.issue_o.ptr, tbl[r].e_iptr);
            chk($sformatf("tbl%0d_commit_valid", r), bus.commit_valid, tbl[r].e_cv);
            chk($sformatf("tbl%0d_commit_pc", r), bus.commit_pc, tbl[r].e_cpc);
            chk($sformatf("tbl%0d_count", r), bus.count, tbl[r].e_cnt);
            chk($sformatf("tbl%0d_flush", r), bus.flush, 0);
            drive_alloc(tbl[r].av[0], rob_dep_t'(tbl[r].dep));
            bus.issue_ready  = tbl[r].ir[0];
            bus.wb_valid     = tbl[r].wv[0];
            bus.wb_ptr       = IW'(tbl[r].wp);
            bus.wb_exception = 1'b0;
            @(negedge clk);
        end

        // ---- full queue, commit under full, wrap of alloc_ptr ----
        do_reset();
        for (int i = 0; i < N; i++) begin
            chk("full_fill_ptr", bus.alloc_ptr, i);
            drive_alloc(1'b1, NODEP);
            @(negedge clk);
        end
        chk("full_count", bus.count, N);
        chk("full_alloc_ready", bus.alloc_ready, 0);
        chk("full_issue_valid", bus.issue_o.valid, 1);
        bus.issue_ready = 1'b1;
        @(negedge clk);
        chk("full_count_refused", bus.count, N);
        bus.issue_ready = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_ptr = '0;
        @(negedge clk);
        chk("full_commit_valid", bus.commit_valid, 1);
        chk("full_ready_during_commit", bus.alloc_ready, 0);
        bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("full_count_after_commit", bus.count, N - 1);
        chk("full_ready_after_commit", bus.alloc_ready, 1);
        chk("full_wrap_ptr", bus.alloc_ptr, 0);
        @(negedge clk);
        chk("full_count_refill", bus.count, N);
        chk("full_ptr_after_wrap", bus.alloc_ptr, 1);
        chk("full_ready_refill", bus.alloc_ready, 0);
        set_idle();

        // ---- exception at head -> one-cycle flush ----
        do_reset();
        drive_alloc(1'b1, NODEP);
        @(negedge clk);
        drive_alloc(1'b1, NODEP);
        bus.issue_ready = 1'b1;
        @(negedge clk);
        drive_alloc(1'b0, NODEP);
        bus.issue_ready = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_ptr = '0;
        bus.wb_exception = 1'b1;
        @(negedge clk);
        chk("exc_pre_flush", bus.flush, 0);
        chk("exc_no_commit", bus.commit_valid, 0);
        chk("exc_count", bus.count, 2);
        bus.wb_valid = 1'b0;
        bus.wb_exception = 1'b0;
        drive_alloc(1'b1, NODEP);
        @(negedge clk);
        chk("exc_flush", bus.flush, 1);
        chk("exc_redirect", bus.redirect_pc, 32'h1000);
        chk("exc_flush_alloc_ready", bus.alloc_ready, 0);
        chk("exc_flush_issue_valid", bus.issue_o.valid, 0);
        chk("exc_flush_commit", bus.commit_valid, 0);
        chk("exc_flush_count", bus.count, 3);
        bus.wb_valid = 1'b1;
        bus.wb_ptr = IW'(1);
        @(negedge clk);
        chk("exc_flush_end", bus.flush, 0);
        chk("exc_count_cleared", bus.count, 0);
        chk("exc_tail_cleared", bus.alloc_ptr, 0);
        chk("exc_issue_ptr_cleared", bus.issue_o.ptr, 0);
        chk("exc_ready_after", bus.alloc_ready, 1);
        set_idle();
        @(negedge clk);
        chk("exc_drop_alloc", bus.count, 0);
        chk("exc_no_commit_after", bus.commit_valid, 0);

        // ---- reset with 10 live entries ----
        for (int i = 0; i < 10; i++) begin
            drive_alloc(1'b1, NODEP);
            bus.issue_ready = (i % 2) == 0;
            @(negedge clk);
        end
        set_idle();
        chk("live_count", bus.count, 10);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_count", bus.count, 0);
        chk("rst_mid_alloc_ready", bus.alloc_ready, 0);
        chk("rst_mid_alloc_ptr", bus.alloc_ptr, 0);
        chk("rst_mid_issue_valid", bus.issue_o.valid, 0);
        chk("rst_mid_issue_ptr", bus.issue_o.ptr, 0);
        chk("rst_mid_commit", bus.commit_valid, 0);
        chk("rst_mid_flush", bus.flush, 0);
        @(negedge clk);
        rst_n = 1'b1;
        alloc_seq = 0;
        @(negedge clk);
        chk("rst_release_ready", bus.alloc_ready, 1);
        chk("rst_release_ptr", bus.alloc_ptr, 0);
        drive_alloc(1'b1, NODEP);
        @(negedge clk);
        chk("rst_first_alloc_count", bus.count, 1);
        chk("rst_first_alloc_next_ptr", bus.alloc_ptr, 1);
        set_idle();

        // ---- randomized run against the queue model ----
        do_reset();
        mq.delete();
        m_issued = 0; m_next = 0; m_flush = 1'b0; m_commits = 0; m_stalls = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            e_ar   = (!m_flush && mq.size() < N) ? 1 : 0;
            e_iv   = 0;
            e_uop  = '0;
            if (!m_flush && m_issued < mq.size()) begin
                if (mq[m_issued].st == M_RDY && dep_sat(mq[m_issued].d0) && dep_sat(mq[m_issued].d1)) begin
                    e_iv = 1;
                    e_uop = mq[m_issued].uop;
                end
            end
            e_iptr = (m_issued < mq.size()) ? mq[m_issued].ptr : m_next;
            e_cv   = (!m_flush && mq.size() > 0 && mq[0].st == M_DONE) ? 1 : 0;
            e_cpc  = e_cv ? mq[0].pc : '0;
            e_cdst = e_cv ? mq[0].dst : '0;
            e_rpc  = m_flush ? mq[0].pc : '0;
            e_cnt  = mq.size();

            chk("rnd_alloc_ready", bus.alloc_ready, e_ar);
            chk("rnd_alloc_ptr", bus.alloc_ptr, m_next);
            chk("rnd_issue_valid", bus.issue_o.valid, e_iv);
            chk("rnd_issue_ptr", bus.issue_o.ptr, e_iptr);
            if (e_iv != 0) chk("rnd_issue_uop", bus.issue_o.uop, e_uop);
            chk("rnd_commit_valid", bus.commit_valid, e_cv);
            chk("rnd_commit_pc", bus.commit_pc, e_cpc);
            chk("rnd_commit_dest", bus.commit_dest_reg, e_cdst);
            chk("rnd_flush", bus.flush, m_flush);
            chk("rnd_redirect_pc", bus.redirect_pc, e_rpc);
            chk("rnd_count", bus.count, e_cnt);

            // Stimulus; dependencies only point at entries already in flight (or none).
            av = $urandom_range(0, 99) < 60;
            ir = $urandom_range(0, 99) < 70;
            nr.pc  = $urandom;
            nr.uop = 16'($urandom);
            nr.dst = 5'($urandom);
            nr.d0  = NODEP;
            nr.d1  = NODEP;
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                nr.d0 = rob_dep_t'(mq[$urandom_range(0, mq.size() - 1)].ptr);
            if (mq.size() > 0 && $urandom_range(0, 3) == 0)
                nr.d1 = rob_dep_t'(mq[$urandom_range(0, mq.size() - 1)].ptr);
            iss_list.delete();
            foreach (mq[j]) if (mq[j].st == M_ISS) iss_list.push_back(mq[j].ptr);
            wv = 1'b0; wp = 0;
            k = $urandom_range(0, 99);
            if (k < 55 && iss_list.size() > 0) begin
                wv = 1'b1;
                wp = iss_list[$urandom_range(0, iss_list.size() - 1)];
            end else if (k < 65) begin
                wv = 1'b1;
                wp = $urandom_range(0, N - 1);
            end
            wx = $urandom_range(0, 99) < 2;

            bus.alloc_valid = av;
            bus.alloc_entry = '0;
            bus.alloc_entry.pc = nr.pc;
            bus.alloc_entry.next_pc = nr.pc + 32'd4;
            bus.alloc_entry.uop = nr.uop;
            bus.alloc_entry.dest_reg = nr.dst;
            bus.alloc_entry.dependent_entries[0] = nr.d0;
            bus.alloc_entry.dependent_entries[1] = nr.d1;
            bus.alloc_entry.status = ST_DONE;
            bus.issue_ready = ir;
            bus.wb_valid = wv;
            bus.wb_ptr = IW'(wp);
            bus.wb_exception = wx;

            // Model update for the coming edge.
            if (av && e_ar == 0) m_stalls++;
            if (m_flush) begin
                mq.delete();
                m_issued = 0;
                m_next = 0;
                m_flush = 1'b0;
            end else begin
                go    = mq.size() > 0 && mq[0].st == M_EXC;
                ifire = (e_iv != 0) && ir;
                afire = av && (e_ar != 0);
                if (wv) begin
                    k = mfind(wp);
                    if (k >= 0 && mq[k].st == M_ISS) mq[k].st = wx ? M_EXC : M_DONE;
                end
                if (ifire) begin
                    mq[m_issued].st = M_ISS;
                    m_issued++;
                end
                if (e_cv != 0) begin
                    void'(mq.pop_front());
                    m_issued--;
                    m_commits++;
                end
                if (afire) begin
                    nr.ptr = m_next;
                    nr.st  = M_RDY;
                    mq.push_back(nr);
                    m_next = (m_next + 1) % N;
                end
                m_flush = go;
            end
            @(negedge clk);
        end
`ifdef ROB_PERF_CNT_EN
        chk("perf_commits", bus.perf_commits, m_commits);
        chk("perf_full_stalls", bus.perf_full_stalls, m_stalls);
`endif
        set_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
